// File: rtl/ntt_bram_wrapper.sv
// In-place 256-point NTT/INTT over Z_3329 on a single-port 256x16 block RAM.
// Each butterfly takes four cycles on the single port: read u, read v, write u+v*tw, write u-v*tw.

module ntt_bram (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  logic [15:0] blockram [0:255];

  always_ff @(posedge clk) begin
    if (we) blockram[addr] <= wdata;
    rdata <= blockram[addr];
  end
endmodule

module ntt_bram_wrapper (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  output logic done
);
  localparam int unsigned Q     = 3329;
  localparam int unsigned W     = 17;
  localparam int unsigned W_INV = 1175;
  localparam int unsigned N_INV = 3316;

  typedef enum logic [2:0] {S_IDLE, S_BITREV, S_STAGE, S_SCALE, S_DONE} state_t;

  function automatic int unsigned modpow(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < e; k++) r = (r * b) % Q;
    return r;
  endfunction

  function automatic logic [11:0] mulmod(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] p;
    p = a * b;
    return 12'(p % 24'(Q));
  endfunction

  function automatic logic [11:0] addmod(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 13'(Q)) ? 12'(s - 13'(Q)) : s[11:0];
  endfunction

  function automatic logic [11:0] submod(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[12] ? 12'(d + 13'(Q)) : d[11:0];
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int unsigned b = 0; b < 8; b++) r[b] = x[7 - b];
    return r;
  endfunction

  // Twiddle ROMs: entry k holds base^k mod Q, filled at elaboration.
  logic [11:0] rom_f [128];
  logic [11:0] rom_i [128];
  for (genvar k = 0; k < 128; k++) begin : g_tw
    localparam logic [11:0] TWF = 12'(modpow(W, k));
    localparam logic [11:0] TWI = 12'(modpow(W_INV, k));
    assign rom_f[k] = TWF;
    assign rom_i[k] = TWI;
  end

  state_t      state, state_n;
  logic [1:0]  ph, ph_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  stg, stg_n;
  logic        mode_q, mode_n;
  logic [15:0] u_q, u_n;
  logic [11:0] t_q, t_n;
  logic [11:0] tw_q, tw_n;

  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic [7:0]  rev;
  logic [7:0]  len;
  logic [6:0]  jmask;
  logic [6:0]  j;
  logic [7:0]  pa;
  logic [7:0]  pb;
  logic [6:0]  tw_idx;
  logic [11:0] tw_rom;
  logic [11:0] mul_b;
  logic [11:0] mul_r;

  ntt_bram u_bram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Butterfly k of stage s: p = (k with low s bits cleared) * 2 + j, partner p + len.
  always_comb begin
    rev    = rev8(cnt);
    len    = 8'd1 << stg;
    jmask  = 7'(len - 8'd1);
    j      = cnt[6:0] & jmask;
    pa     = {cnt[6:0] & ~jmask, 1'b0} | {1'b0, j};
    pb     = pa | len;
    tw_idx = j << (3'd7 - stg);
    tw_rom = mode_q ? rom_i[tw_idx] : rom_f[tw_idx];
    mul_b  = (state == S_SCALE) ? 12'(N_INV) : tw_q;
    mul_r  = mulmod(ram_rdata[11:0], mul_b);
  end

  always_comb begin
    state_n   = state;
    ph_n      = ph;
    cnt_n     = cnt;
    stg_n     = stg;
    mode_n    = mode_q;
    u_n       = u_q;
    t_n       = t_q;
    tw_n      = tw_q;
    ram_we    = 1'b0;
    ram_addr  = cnt;
    ram_wdata = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_BITREV;
          mode_n  = mode;
          cnt_n   = '0;
          ph_n    = '0;
          stg_n   = '0;
        end
      end
      S_BITREV: begin
        case (ph)
          2'd0: begin
            if (cnt < rev) begin
              ram_addr = cnt;
              ph_n     = 2'd1;
            end else if (cnt == 8'd255) begin
              state_n = S_STAGE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end
          2'd1: begin
            ram_addr = rev;
            u_n      = ram_rdata;
            ph_n     = 2'd2;
          end
          2'd2: begin
            ram_we    = 1'b1;
            ram_addr  = cnt;
            ram_wdata = ram_rdata;
            ph_n      = 2'd3;
          end
          default: begin
            ram_we    = 1'b1;
            ram_addr  = rev;
            ram_wdata = u_q;
            ph_n      = 2'd0;
            cnt_n     = cnt + 8'd1;
          end
        endcase
      end
      S_STAGE: begin
        case (ph)
          2'd0: begin
            ram_addr = pa;
            tw_n     = tw_rom;
            ph_n     = 2'd1;
          end
          2'd1: begin
            ram_addr = pb;
            u_n      = {4'd0, ram_rdata[11:0]};
            ph_n     = 2'd2;
          end
          2'd2: begin
            ram_we    = 1'b1;
            ram_addr  = pa;
            ram_wdata = {4'd0, addmod(u_q[11:0], mul_r)};
            t_n       = mul_r;
            ph_n      = 2'd3;
          end
          default: begin
            ram_we    = 1'b1;
            ram_addr  = pb;
            ram_wdata = {4'd0, submod(u_q[11:0], t_q)};
            ph_n      = 2'd0;
            if (cnt == 8'd127) begin
              cnt_n = '0;
              if (stg == 3'd7) state_n = mode_q ? S_SCALE : S_DONE;
              else stg_n = stg + 3'd1;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end
        endcase
      end
      S_SCALE: begin
        if (ph == 2'd0) begin
          ram_addr = cnt;
          ph_n     = 2'd1;
        end else begin
          ram_we    = 1'b1;
          ram_addr  = cnt;
          ram_wdata = {4'd0, mul_r};
          ph_n      = 2'd0;
          if (cnt == 8'd255) begin
            state_n = S_DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ph     <= '0;
      cnt    <= '0;
      stg    <= '0;
      mode_q <= 1'b0;
      u_q    <= '0;
      t_q    <= '0;
      tw_q   <= '0;
    end else begin
      state  <= state_n;
      ph     <= ph_n;
      cnt    <= cnt_n;
      stg    <= stg_n;
      mode_q <= mode_n;
      u_q    <= u_n;
      t_q    <= t_n;
      tw_q   <= tw_n;
    end
  end

  assign done = (state == S_DONE);
endmodule

// File: tb/tb_ntt_bram_wrapper.sv
// Directed bench for ntt_bram_wrapper: known transforms, DFT model on a random vector, round trip, reset mid-run.
module tb_ntt_bram_wrapper;
  localparam int unsigned Q = 3329;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode;
  logic done;

  int total = 0;
  int bad = 0;
  int lat_ntt = 0;
  int lat_intt = 0;

  int unsigned pw   [256];
  int unsigned vec  [256];
  int unsigned expv [256];
  int unsigned orig [256];

  always #5 clk = ~clk;

  ntt_bram_wrapper uut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .done  (done)
  );

  task automatic load_vec();
    for (int i = 0; i < 256; i++) uut.u_bram.blockram[i] = 16'(vec[i]);
  endtask

  // Start held for two edges, mode flipped afterwards; optional one-cycle start poke while busy.
  task automatic run_xform(input logic m, input int poke, output int cyc, output int pulses);
    cyc = 0;
    pulses = 0;
    @(posedge clk); #1; mode = m; start = 1'b1;
    @(posedge clk); #1; cyc = 1;
    @(posedge clk); #1; start = 1'b0; mode = ~m; cyc = 2;
    while (done !== 1'b1 && cyc < 9000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke != 0) start = (cyc == poke);
    end
    start = 1'b0;
    if (done === 1'b1) begin
      pulses = 1;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (done === 1'b1) pulses++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b required 0", done); end
    total++; if (int'(uut.state) != 0) begin bad++; $display("FAIL reset_state: got %0d required 0", int'(uut.state)); end
    total++; if (uut.cnt !== 8'd0 || uut.stg !== 3'd0 || uut.ph !== 2'd0) begin
      bad++; $display("FAIL reset_counters: cnt=%0d stg=%0d ph=%0d required 0", uut.cnt, uut.stg, uut.ph);
    end
    total++; if (uut.mode_q !== 1'b0) begin bad++; $display("FAIL reset_mode: got %0b required 0", uut.mode_q); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int cyc, pulses, nbad, fi;
    foreach (vec[i]) vec[i] = 0;
    vec[0] = 1;
    load_vec();
    run_xform(1'b0, 0, cyc, pulses);
    lat_ntt = cyc;
    total++; if (pulses !== 1) begin bad++; $display("FAIL impulse_pulses: got %0d required 1", pulses); end
    total++; if (cyc > 8192) begin bad++; $display("FAIL impulse_latency: got %0d required <= 8192", cyc); end
    nbad = 0; fi = 0;
    for (int i = 0; i < 256; i++) if (uut.u_bram.blockram[i] !== 16'd1) begin if (nbad == 0) fi = i; nbad++; end
    total++; if (nbad != 0) begin
      bad++; $display("FAIL impulse_data: A[%0d]=%0d required 1 (%0d wrong)", fi, uut.u_bram.blockram[fi], nbad);
    end
  endtask

  task automatic test_constant();
    int cyc, pulses, nbad, fi;
    foreach (vec[i]) vec[i] = 1;
    foreach (expv[i]) expv[i] = 0;
    expv[0] = 256;
    load_vec();
    run_xform(1'b0, 0, cyc, pulses);
    total++; if (pulses !== 1) begin bad++; $display("FAIL constant_pulses: got %0d required 1", pulses); end
    total++; if (cyc != lat_ntt) begin bad++; $display("FAIL constant_latency: got %0d required %0d", cyc, lat_ntt); end
    nbad = 0; fi = 0;
    for (int i = 0; i < 256; i++) if (uut.u_bram.blockram[i] !== 16'(expv[i])) begin if (nbad == 0) fi = i; nbad++; end
    total++; if (nbad != 0) begin
      bad++; $display("FAIL constant_data: A[%0d]=%0d required %0d (%0d wrong)", fi, uut.u_bram.blockram[fi], expv[fi], nbad);
    end
  endtask

  task automatic test_shifted();
    int cyc, pulses, nbad, fi;
    foreach (vec[i]) vec[i] = 0;
    vec[1] = 1;
    load_vec();
    run_xform(1'b0, 0, cyc, pulses);
    total++; if (pulses !== 1) begin bad++; $display("FAIL shifted_pulses: got %0d required 1", pulses); end
    total++; if (uut.u_bram.blockram[3] !== 16'd1584) begin
      bad++; $display("FAIL shifted_a3: got %0d required 1584", uut.u_bram.blockram[3]);
    end
    nbad = 0; fi = 0;
    for (int i = 0; i < 256; i++) if (uut.u_bram.blockram[i] !== 16'(pw[i])) begin if (nbad == 0) fi = i; nbad++; end
    total++; if (nbad != 0) begin
      bad++; $display("FAIL shifted_data: A[%0d]=%0d required %0d (%0d wrong)", fi, uut.u_bram.blockram[fi], pw[fi], nbad);
    end
  endtask

  task automatic test_intt_const();
    int cyc, pulses, nbad, fi;
    foreach (vec[i]) vec[i] = 1;
    foreach (expv[i]) expv[i] = 0;
    expv[0] = 1;
    load_vec();
    run_xform(1'b1, 0, cyc, pulses);
    lat_intt = cyc;
    total++; if (pulses !== 1) begin bad++; $display("FAIL intt_pulses: got %0d required 1", pulses); end
    total++; if (cyc > 8192) begin bad++; $display("FAIL intt_latency: got %0d required <= 8192", cyc); end
    nbad = 0; fi = 0;
    for (int i = 0; i < 256; i++) if (uut.u_bram.blockram[i] !== 16'(expv[i])) begin if (nbad == 0) fi = i; nbad++; end
    total++; if (nbad != 0) begin
      bad++; $display("FAIL intt_data: A[%0d]=%0d required %0d (%0d wrong)", fi, uut.u_bram.blockram[fi], expv[fi], nbad);
    end
  endtask

  task automatic test_roundtrip();
    int cyc, pulses, nbad, fi;
    int unsigned acc;
    foreach (vec[i]) begin vec[i] = $urandom_range(Q - 1); orig[i] = vec[i]; end
    for (int k = 0; k < 256; k++) begin
      acc = 0;
      for (int jj = 0; jj < 256; jj++) acc = (acc + vec[jj] * pw[(jj * k) % 256]) % Q;
      expv[k] = acc;
    end
    load_vec();
    run_xform(1'b0, 0, cyc, pulses);
    total++; if (cyc != lat_ntt || pulses !== 1) begin
      bad++; $display("FAIL rand_ntt_run: latency %0d pulses %0d required %0d and 1", cyc, pulses, lat_ntt);
    end
    nbad = 0; fi = 0;
    for (int i = 0; i < 256; i++) if (uut.u_bram.blockram[i] !== 16'(expv[i])) begin if (nbad == 0) fi = i; nbad++; end
    total++; if (nbad != 0) begin
      bad++; $display("FAIL rand_ntt_data: A[%0d]=%0d required %0d (%0d wrong)", fi, uut.u_bram.blockram[fi], expv[fi], nbad);
    end
    run_xform(1'b1, 0, cyc, pulses);
    total++; if (cyc != lat_intt || pulses !== 1) begin
      bad++; $display("FAIL rand_intt_run: latency %0d pulses %0d required %0d and 1", cyc, pulses, lat_intt);
    end
    nbad = 0; fi = 0;
    for (int i = 0; i < 256; i++) if (uut.u_bram.blockram[i] !== 16'(orig[i])) begin if (nbad == 0) fi = i; nbad++; end
    total++; if (nbad != 0) begin
      bad++; $display("FAIL roundtrip_data: A[%0d]=%0d required %0d (%0d wrong)", fi, uut.u_bram.blockram[fi], orig[fi], nbad);
    end
  endtask

  task automatic test_reset_midrun();
    int n, highs, cyc, pulses, nbad, fi;
    foreach (vec[i]) vec[i] = 1;
    load_vec();
    @(posedge clk); #1; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!(int'(uut.state) == 2 && uut.stg == 3'd3) && n < 9000) begin @(posedge clk); #1; n++; end
    total++; if (n >= 9000) begin bad++; $display("FAIL midrun_reach_stage3: waited %0d cycles, required < 9000", n); end
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    total++; if (int'(uut.state) != 0 || done !== 1'b0) begin
      bad++; $display("FAIL midrun_async_reset: state=%0d done=%0b required 0 and 0", int'(uut.state), done);
    end
    highs = 0;
    repeat (3) begin @(posedge clk); #1; if (done !== 1'b0) highs++; end
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done !== 1'b0) highs++; end
    total++; if (highs != 0) begin bad++; $display("FAIL midrun_done_quiet: done high %0d cycles required 0", highs); end
    foreach (vec[i]) vec[i] = 0;
    vec[1] = 1;
    load_vec();
    run_xform(1'b0, 200, cyc, pulses);
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_start_pulses: got %0d required 1", pulses); end
    total++; if (cyc != lat_ntt) begin bad++; $display("FAIL busy_start_latency: got %0d required %0d", cyc, lat_ntt); end
    nbad = 0; fi = 0;
    for (int i = 0; i < 256; i++) if (uut.u_bram.blockram[i] !== 16'(pw[i])) begin if (nbad == 0) fi = i; nbad++; end
    total++; if (nbad != 0) begin
      bad++; $display("FAIL after_reset_data: A[%0d]=%0d required %0d (%0d wrong)", fi, uut.u_bram.blockram[fi], pw[fi], nbad);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    pw[0] = 1;
    for (int k = 1; k < 256; k++) pw[k] = (pw[k - 1] * 17) % Q;
    test_reset();
    test_impulse();
    test_constant();
    test_shifted();
    test_intt_const();
    test_roundtrip();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
